hs_sync_rx: RTL and testbench

HS_SYNC_RX -- requirements
Module: hs_sync_rx

---
 rtl/hs_sync_rx.sv | 132 +++++++++++++
 tb/tb_hs_sync_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_sync_rx.sv
// hs_sync_rx -- destination side of a four-phase req/ack clock-domain crossing.
//
// The source raises SRC_REQ with SRC_DATA held stable; the request level is
// synchronised into CLKB, the data word is captured once, offered downstream
// on DST_VALID/DST_READY, and acknowledged back with the SRC_ACK level. A new
// capture is only allowed after the request has been seen low again.
//
// Ports
//   CLKB       in   destination clock, rising edge
//   RST        in   asynchronous reset, active low
//   SRC_REQ    in   source request level (asynchronous to CLKB)
//   SRC_DATA   in   source data word (not synchronised, sampled on capture)
//   DST_READY  in   downstream consumer ready
//   DST_DATA   out  captured data word
//   DST_VALID  out  DST_DATA valid
//   SRC_ACK    out  acknowledge level back to the source domain
//   PROTO_ERR  out  sticky flag: request withdrawn before acknowledge
//   XFER_CNT   out  completed transfer count, wraps at 256
module hs_sync_rx #(
    parameter int unsigned NUM_STAGES = 2,   // legal range 2..4
    parameter int unsigned BUS_WIDTH  = 8
) (
    input  logic                 CLKB,
    input  logic                 RST,
    input  logic                 SRC_REQ,
    input  logic [BUS_WIDTH-1:0] SRC_DATA,
    input  logic                 DST_READY,
    output logic [BUS_WIDTH-1:0] DST_DATA,
    output logic                 DST_VALID,
    output logic                 SRC_ACK,
    output logic                 PROTO_ERR,
    output logic [7:0]           XFER_CNT
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        VALID = 2'b01,
        ACK   = 2'b10
    } state_t;

    state_t                 state_q, state_nxt;
    logic [NUM_STAGES-1:0]  req_sync;
    logic                   req_s;

    logic [BUS_WIDTH-1:0]   data_nxt;
    logic                   valid_nxt;
    logic                   ack_nxt;
    logic                   err_nxt;
    logic [7:0]             cnt_nxt;

    // Request synchroniser; only the last stage is used by the logic.
    always_ff @(posedge CLKB or negedge RST) begin
        if (!RST) begin
            req_sync <= '0;
        end else begin
            req_sync <= {req_sync[NUM_STAGES-2:0], SRC_REQ};
        end
    end

    assign req_s = req_sync[NUM_STAGES-1];

    // State and all outputs registered together so no input reaches an
    // output combinationally.
    always_ff @(posedge CLKB or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            DST_DATA  <= '0;
            DST_VALID <= 1'b0;
            SRC_ACK   <= 1'b0;
            PROTO_ERR <= 1'b0;
            XFER_CNT  <= '0;
        end else begin
            state_q   <= state_nxt;
            DST_DATA  <= data_nxt;
            DST_VALID <= valid_nxt;
            SRC_ACK   <= ack_nxt;
            PROTO_ERR <= err_nxt;
            XFER_CNT  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        data_nxt  = DST_DATA;
        valid_nxt = DST_VALID;
        ack_nxt   = SRC_ACK;
        err_nxt   = PROTO_ERR;
        cnt_nxt   = XFER_CNT;

        case (state_q)
            IDLE: begin
                // SRC_DATA is stable here because the source holds it while
                // its request is high, so no data synchroniser is needed.
                if (req_s) begin
                    data_nxt  = SRC_DATA;
                    valid_nxt = 1'b1;
                    state_nxt = VALID;
                end
            end

            VALID: begin
                // Early withdrawal is flagged but the held word is still
                // delivered and the handshake completes normally.
                if (!req_s) begin
                    err_nxt = 1'b1;
                end
                if (DST_READY) begin
                    valid_nxt = 1'b0;
                    ack_nxt   = 1'b1;
                    cnt_nxt   = XFER_CNT + 8'd1;
                    state_nxt = ACK;
                end
            end

            ACK: begin
                // Stay here until the request is seen low, so one request
                // level yields exactly one transfer.
                if (!req_s) begin
                    ack_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                ack_nxt   = 1'b0;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hs_sync_rx.sv
// tb_hs_sync_rx -- scoreboard bench for hs_sync_rx (NUM_STAGES=2, BUS_WIDTH=8).
// Stimulus pushes each word it expects to be delivered; a forked monitor pops
// and compares on every DST_VALID && DST_READY handshake.
module tb_hs_sync_rx;

    logic       CLKB = 1'b0;
    logic       RST = 1'b0;
    logic       SRC_REQ = 1'b0;
    logic [7:0] SRC_DATA = 8'h00;
    logic       DST_READY = 1'b0;
    logic [7:0] DST_DATA;
    logic       DST_VALID;
    logic       SRC_ACK;
    logic       PROTO_ERR;
    logic [7:0] XFER_CNT;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_cnt = 8'h00;

    hs_sync_rx #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut (
        .CLKB      (CLKB),
        .RST       (RST),
        .SRC_REQ   (SRC_REQ),
        .SRC_DATA  (SRC_DATA),
        .DST_READY (DST_READY),
        .DST_DATA  (DST_DATA),
        .DST_VALID (DST_VALID),
        .SRC_ACK   (SRC_ACK),
        .PROTO_ERR (PROTO_ERR),
        .XFER_CNT  (XFER_CNT)
    );

    always #5 CLKB = ~CLKB;

    task automatic tick();
        @(posedge CLKB);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h t=%0t", name, act, exp, $time);
        end
    endtask

    // Bounded wait for SRC_ACK to reach a level; expiry shows as a failed check.
    task automatic wait_ack(input logic want, input string name);
        for (int i = 0; i < 20; i++) begin
            if (SRC_ACK === want) break;
            tick();
        end
        chk1(name, SRC_ACK, want);
    endtask

    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge CLKB);
            if (RST === 1'b1 && DST_VALID === 1'b1 && DST_READY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=%02h required=no_transfer t=%0t", DST_DATA, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk8("sb_data", DST_DATA, e);
                end
            end
        end
    endtask

    // One clean four-phase transfer with the consumer always ready.
    task automatic xfer(input logic [7:0] d);
        exp_q.push_back(d);
        SRC_DATA  = d;
        DST_READY = 1'b1;
        SRC_REQ   = 1'b1;
        wait_ack(1'b1, "xf_ack_rise");
        exp_cnt++;
        chk8("xf_cnt", XFER_CNT, exp_cnt);
        SRC_REQ = 1'b0;
        wait_ack(1'b0, "xf_ack_fall");
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Reset state
        #1;
        chk1("rst_valid", DST_VALID, 1'b0);
        chk1("rst_ack", SRC_ACK, 1'b0);
        chk1("rst_err", PROTO_ERR, 1'b0);
        chk8("rst_data", DST_DATA, 8'h00);
        chk8("rst_cnt", XFER_CNT, 8'h00);
        repeat (3) @(posedge CLKB);
        #1;
        RST = 1'b1;
        tick();

        // Basic transfer and latency
        SRC_DATA  = 8'hA5;
        DST_READY = 1'b1;
        SRC_REQ   = 1'b1;
        exp_q.push_back(8'hA5);
        tick(); tick();
        chk1("lat_valid_e2", DST_VALID, 1'b0);
        tick();
        chk1("lat_valid_e3", DST_VALID, 1'b1);
        chk8("lat_data_e3", DST_DATA, 8'hA5);
        chk1("lat_ack_e3", SRC_ACK, 1'b0);
        tick();
        chk1("basic_ack_e4", SRC_ACK, 1'b1);
        chk1("basic_valid_e4", DST_VALID, 1'b0);
        exp_cnt++;
        chk8("basic_cnt", XFER_CNT, exp_cnt);
        SRC_REQ = 1'b0;
        tick(); tick();
        chk1("basic_ack_rel2", SRC_ACK, 1'b1);
        tick();
        chk1("basic_ack_rel3", SRC_ACK, 1'b0);
        SRC_DATA = 8'hFF;
        repeat (3) tick();
        chk8("data_retain", DST_DATA, 8'hA5);
        chk1("idle_valid", DST_VALID, 1'b0);

        // Backpressure
        DST_READY = 1'b0;
        SRC_DATA  = 8'hA5;
        SRC_REQ   = 1'b1;
        exp_q.push_back(8'hA5);
        repeat (3) tick();
        chk1("bp_valid", DST_VALID, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("bp_valid_hold", DST_VALID, 1'b1);
            chk8("bp_data_hold", DST_DATA, 8'hA5);
            chk1("bp_ack_low", SRC_ACK, 1'b0);
        end
        DST_READY = 1'b1;
        tick();
        chk1("bp_ack", SRC_ACK, 1'b1);
        exp_cnt++;
        chk8("bp_cnt", XFER_CNT, exp_cnt);
        SRC_REQ = 1'b0;
        wait_ack(1'b0, "bp_ack_fall");

        // Level hold: one request level, one transfer
        SRC_DATA = 8'h5A;
        SRC_REQ  = 1'b1;
        exp_q.push_back(8'h5A);
        wait_ack(1'b1, "lh_ack_rise");
        exp_cnt++;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk1("lh_ack_hold", SRC_ACK, 1'b1);
            chk1("lh_no_recapture", DST_VALID, 1'b0);
        end
        chk8("lh_cnt_once", XFER_CNT, exp_cnt);
        SRC_REQ = 1'b0;
        wait_ack(1'b0, "lh_ack_fall");

        // Early withdrawal
        DST_READY = 1'b0;
        SRC_DATA  = 8'h77;
        SRC_REQ   = 1'b1;
        exp_q.push_back(8'h77);
        repeat (3) tick();
        chk1("ew_valid", DST_VALID, 1'b1);
        chk1("ew_err_clean", PROTO_ERR, 1'b0);
        SRC_REQ = 1'b0;
        tick(); tick();
        chk1("ew_err_pre", PROTO_ERR, 1'b0);
        tick();
        chk1("ew_err_set", PROTO_ERR, 1'b1);
        chk1("ew_valid_held", DST_VALID, 1'b1);
        chk8("ew_data_held", DST_DATA, 8'h77);
        DST_READY = 1'b1;
        tick();
        chk1("ew_ack", SRC_ACK, 1'b1);
        exp_cnt++;
        chk8("ew_cnt", XFER_CNT, exp_cnt);
        tick();
        chk1("ew_ack_fall", SRC_ACK, 1'b0);
        for (int i = 0; i < 3; i++) xfer(8'h10 + 8'(i));
        chk1("ew_err_sticky", PROTO_ERR, 1'b1);

        // Asynchronous reset while in VALID, then re-request
        DST_READY = 1'b0;
        SRC_DATA  = 8'hC3;
        SRC_REQ   = 1'b1;
        repeat (3) tick();
        chk1("ar_valid_pre", DST_VALID, 1'b1);
        #2;
        RST = 1'b0;
        #1;
        chk1("ar_valid", DST_VALID, 1'b0);
        chk1("ar_ack", SRC_ACK, 1'b0);
        chk1("ar_err", PROTO_ERR, 1'b0);
        chk8("ar_data", DST_DATA, 8'h00);
        chk8("ar_cnt", XFER_CNT, 8'h00);
        exp_cnt = 8'h00;
        @(posedge CLKB);
        #1;
        RST = 1'b1;
        exp_q.push_back(8'hC3);
        tick(); tick();
        chk1("rr_valid_e2", DST_VALID, 1'b0);
        tick();
        chk1("rr_valid_e3", DST_VALID, 1'b1);
        chk8("rr_data", DST_DATA, 8'hC3);
        DST_READY = 1'b1;
        tick();
        chk1("rr_ack", SRC_ACK, 1'b1);
        exp_cnt++;
        chk8("rr_cnt", XFER_CNT, exp_cnt);
        SRC_REQ = 1'b0;
        wait_ack(1'b0, "rr_ack_fall");

        // Counter wrap from a fresh reset
        #2;
        RST = 1'b0;
        #1;
        chk8("wr_cnt_rst", XFER_CNT, 8'h00);
        exp_cnt = 8'h00;
        @(posedge CLKB);
        #1;
        RST = 1'b1;
        tick();
        for (int i = 0; i < 255; i++) xfer(8'(i));
        chk8("wr_cnt_255", XFER_CNT, 8'hFF);
        xfer(8'hE7);
        chk8("wr_cnt_wrap", XFER_CNT, 8'h00);

        repeat (2) tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
